// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: 3-sample mid-bit majority vote, 5..9 data bits,
// runtime parity, 1/2 stop bits, single-entry holding register with overrun flag.
module uart_rx_os #(
  parameter int WIDTH_DATA = 8,
  parameter int OS         = 16,
  parameter int STOP_BITS  = 1
) (
  input  logic                  i_clk,
  input  logic                  i_nrst,
  input  logic                  i_tick,
  input  logic                  i_rx,
  input  logic [1:0]            i_parity,
  input  logic                  i_re,
  output logic [WIDTH_DATA-1:0] o_data,
  output logic                  o_rdy,
  output logic                  o_perr,
  output logic                  o_ferr,
  output logic                  o_ovr,
  output logic                  o_busy
);
  // state  | meaning
  // IDLE   | waiting for a falling edge on the synchronized line
  // START  | validating the start bit by mid-bit vote
  // DATA   | shifting in WIDTH_DATA bits, LSB first
  // PARITY | checking the parity bit against the latched mode
  // STOP   | voting stop bits; the last vote commits the frame

  localparam int TCW = $clog2(OS);
  localparam int BCW = (WIDTH_DATA > 2) ? $clog2(WIDTH_DATA) : 1;
  localparam logic [TCW-1:0] TC_S0   = TCW'(OS/2 - 1);
  localparam logic [TCW-1:0] TC_S1   = TCW'(OS/2);
  localparam logic [TCW-1:0] TC_VOTE = TCW'(OS/2 + 1);
  localparam logic [TCW-1:0] TC_END  = TCW'(OS - 1);
  localparam logic [BCW-1:0] BC_DATA_LAST = BCW'(WIDTH_DATA - 1);
  localparam logic [BCW-1:0] BC_STOP_LAST = BCW'(STOP_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t                state, state_nxt;
  logic                  rx_s1, rx_s2, rx_prev;
  logic                  fall;
  logic [TCW-1:0]        tc;
  logic [BCW-1:0]        bit_cnt;
  logic [1:0]            smp;
  logic                  vote;
  logic                  tick_vote, tick_end;
  logic [WIDTH_DATA-1:0] shreg;
  logic                  par_en, par_odd;
  logic                  perr_acc, ferr_acc, ferr_now;
  logic                  commit;

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= i_rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  assign fall      = rx_prev & ~rx_s2;
  assign tick_vote = i_tick && (tc == TC_VOTE);
  assign tick_end  = i_tick && (tc == TC_END);
  // third sample is the live synchronized value on the deciding tick
  assign vote      = (smp[0] & smp[1]) | (smp[0] & rx_s2) | (smp[1] & rx_s2);
  assign ferr_now  = ferr_acc | ~vote;
  assign o_busy    = (state != S_IDLE);

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    commit    = 1'b0;
    case (state)
      S_IDLE:   if (fall) state_nxt = S_START;
      S_START: begin
        if (tick_vote && vote) state_nxt = S_IDLE;
        else if (tick_end)     state_nxt = S_DATA;
      end
      S_DATA:   if (tick_end && bit_cnt == BC_DATA_LAST)
                  state_nxt = par_en ? S_PARITY : S_STOP;
      S_PARITY: if (tick_end) state_nxt = S_STOP;
      S_STOP: begin
        // leave on the vote, not the bit end, so an early next start edge is caught
        if (tick_vote && bit_cnt == BC_STOP_LAST) begin
          state_nxt = S_IDLE;
          commit    = 1'b1;
        end
      end
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      tc       <= '0;
      bit_cnt  <= '0;
      smp      <= 2'b11;
      shreg    <= '0;
      par_en   <= 1'b0;
      par_odd  <= 1'b0;
      perr_acc <= 1'b0;
      ferr_acc <= 1'b0;
    end else if (state == S_IDLE) begin
      tc       <= '0;
      bit_cnt  <= '0;
      perr_acc <= 1'b0;
      ferr_acc <= 1'b0;
      par_en   <= i_parity[1];
      par_odd  <= i_parity[0];
    end else if (i_tick) begin
      tc <= (tc == TC_END) ? '0 : tc + 1'b1;
      if (tc == TC_S0) smp[0] <= rx_s2;
      if (tc == TC_S1) smp[1] <= rx_s2;
      if (tc == TC_VOTE) begin
        case (state)
          S_DATA:   shreg    <= {vote, shreg[WIDTH_DATA-1:1]};
          S_PARITY: perr_acc <= ^shreg ^ vote ^ par_odd;
          S_STOP:   if (!vote) ferr_acc <= 1'b1;
          default:  ;
        endcase
      end
      if (tc == TC_END) begin
        if (state_nxt != state) bit_cnt <= '0;
        else                    bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      o_data <= '1;
      o_rdy  <= 1'b0;
      o_perr <= 1'b0;
      o_ferr <= 1'b0;
      o_ovr  <= 1'b0;
    end else begin
      if (commit && (!o_rdy || i_re)) begin
        o_data <= shreg;
        o_perr <= perr_acc;
        o_ferr <= ferr_now;
        o_rdy  <= 1'b1;
      end else if (i_re) begin
        o_rdy  <= 1'b0;
        o_perr <= 1'b0;
        o_ferr <= 1'b0;
      end
      if (commit && o_rdy && !i_re) o_ovr <= 1'b1;
      else if (i_re)                o_ovr <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// Scoreboard bench for uart_rx_os: four instances (8N1/16, 8N2/16, 5N1/8, 9N2/8)
// driven with tick-aligned directed frames; a monitor checks every delivered frame.
module tb_uart_rx_os;
  logic       i_clk = 1'b0;
  logic       i_nrst, i_tick;
  logic [1:0] parity;
  logic [3:0] rx, re;
  logic [7:0] d0, d1;
  logic [4:0] d2;
  logic [8:0] d3;
  logic [3:0] rdy_v, perr_v, ferr_v, ovr_v, busy_v;
  logic [3:0] rdy_p = '0, re_p = '0;
  logic [10:0] q0[$], q1[$], q2[$], q3[$];
  int checks = 0, errors = 0;
  int tp = 4;

  always #5 i_clk = ~i_clk;

  uart_rx_os #(.WIDTH_DATA(8), .OS(16), .STOP_BITS(1)) u_a (
    .i_clk(i_clk), .i_nrst(i_nrst), .i_tick(i_tick), .i_rx(rx[0]), .i_parity(parity),
    .i_re(re[0]), .o_data(d0), .o_rdy(rdy_v[0]), .o_perr(perr_v[0]), .o_ferr(ferr_v[0]),
    .o_ovr(ovr_v[0]), .o_busy(busy_v[0]));
  uart_rx_os #(.WIDTH_DATA(8), .OS(16), .STOP_BITS(2)) u_b (
    .i_clk(i_clk), .i_nrst(i_nrst), .i_tick(i_tick), .i_rx(rx[1]), .i_parity(parity),
    .i_re(re[1]), .o_data(d1), .o_rdy(rdy_v[1]), .o_perr(perr_v[1]), .o_ferr(ferr_v[1]),
    .o_ovr(ovr_v[1]), .o_busy(busy_v[1]));
  uart_rx_os #(.WIDTH_DATA(5), .OS(8), .STOP_BITS(1)) u_c (
    .i_clk(i_clk), .i_nrst(i_nrst), .i_tick(i_tick), .i_rx(rx[2]), .i_parity(parity),
    .i_re(re[2]), .o_data(d2), .o_rdy(rdy_v[2]), .o_perr(perr_v[2]), .o_ferr(ferr_v[2]),
    .o_ovr(ovr_v[2]), .o_busy(busy_v[2]));
  uart_rx_os #(.WIDTH_DATA(9), .OS(8), .STOP_BITS(2)) u_d (
    .i_clk(i_clk), .i_nrst(i_nrst), .i_tick(i_tick), .i_rx(rx[3]), .i_parity(parity),
    .i_re(re[3]), .o_data(d3), .o_rdy(rdy_v[3]), .o_perr(perr_v[3]), .o_ferr(ferr_v[3]),
    .o_ovr(ovr_v[3]), .o_busy(busy_v[3]));

  function automatic logic [8:0] dat(input int s);
    case (s)
      0:       return {1'b0, d0};
      1:       return {1'b0, d1};
      2:       return {4'b0, d2};
      default: return d3;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // expected entry: {perr, ferr, data[8:0]}
  task automatic push(input int s, input logic [10:0] e);
    case (s)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      2:       q2.push_back(e);
      default: q3.push_back(e);
    endcase
  endtask

  // a frame is presented when o_rdy rises, or stays high across a read
  always @(negedge i_clk) begin : mon
    logic [10:0] e, got;
    bit have;
    for (int s = 0; s < 4; s++) begin
      if (i_nrst && rdy_v[s] && (!rdy_p[s] || re_p[s])) begin
        got  = {perr_v[s], ferr_v[s], dat(s)};
        have = 1'b0;
        e    = '0;
        case (s)
          0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
          1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
          2: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
          default: if (q3.size() > 0) begin e = q3.pop_front(); have = 1'b1; end
        endcase
        checks++;
        if (!have) begin
          errors++;
          $display("FAIL mon%0d unexpected frame: got %h expected none", s, got);
        end else if (got !== e) begin
          errors++;
          $display("FAIL mon%0d frame {perr,ferr,data}: got %h expected %h", s, got, e);
        end
      end
      rdy_p[s] = rdy_v[s];
      re_p[s]  = re[s];
    end
  end

  // one oversample period: tick high on its first cycle, rx changed with it
  task automatic unit(input int s, input logic val, input bit mk, input bit mk_re, input bit mk_rdy);
    @(posedge i_clk); #1;
    rx[s]  = val;
    i_tick = 1'b1;
    re[s]  = mk & mk_re;
    if (mk) begin
      @(negedge i_clk);
      chk("rdy before final stop vote", rdy_v[s], mk_rdy);
    end
    for (int k = 1; k < tp; k++) begin
      @(posedge i_clk); #1;
      i_tick = 1'b0;
      re[s]  = 1'b0;
      if (mk && k == 1) begin
        @(negedge i_clk);
        chk("rdy on edge after final stop vote", rdy_v[s], 1);
      end
    end
  endtask

  task automatic drive(input int s, input logic val, input int n);
    repeat (n) unit(s, val, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic send(input int s, input logic [8:0] d, input int w, input bit has_p,
                      input bit pbit, input logic [1:0] stops, input int ns, input int os,
                      input int mk_u, input bit mk_re, input bit mk_rdy);
    logic [15:0] bits;
    int n, u;
    bits = '0;
    n = 1;
    for (int i = 0; i < w; i++) begin bits[n] = d[i]; n++; end
    if (has_p) begin bits[n] = pbit; n++; end
    for (int i = 0; i < ns; i++) begin bits[n] = stops[i]; n++; end
    u = 0;
    for (int b = 0; b < n; b++)
      for (int k = 0; k < os; k++) begin
        unit(s, bits[b], (u == mk_u), mk_re, mk_rdy);
        u++;
      end
    drive(s, 1'b1, 2 * os);
    @(posedge i_clk); #1;
    i_tick = 1'b0;
    re     = '0;
  endtask

  task automatic rd(input int s);
    @(posedge i_clk); #1; re[s] = 1'b1;
    @(posedge i_clk); #1; re[s] = 1'b0;
    @(negedge i_clk);
    chk("rdy cleared one cycle after read", rdy_v[s], 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    i_nrst = 1'b0; i_tick = 1'b0; rx = 4'hF; re = '0; parity = 2'b00;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    chk("reset data", d0, 8'hFF);
    chk("reset data w9", d3, 9'h1FF);
    chk("reset rdy", rdy_v, 4'h0);
    chk("reset perr", perr_v, 4'h0);
    chk("reset ferr", ferr_v, 4'h0);
    chk("reset ovr", ovr_v, 4'h0);
    chk("reset busy", busy_v, 4'h0);
    @(posedge i_clk); #1 i_nrst = 1'b1;
    repeat (2) @(posedge i_clk);

    // 8N1 0x55; last stop vote lands on unit 9*16+8+2
    push(0, {2'b00, 9'h055});
    send(0, 9'h055, 8, 1'b0, 1'b0, 2'b11, 1, 16, 154, 1'b0, 1'b0);
    chk("rdy after 0x55", rdy_v[0], 1);
    rd(0);
    chk("data holds after read", d0, 8'h55);

    // 0xA3 has four ones: parity bit 1 is wrong for even, right for odd
    parity = 2'b10;
    push(0, {2'b10, 9'h0A3});
    send(0, 9'h0A3, 8, 1'b1, 1'b1, 2'b11, 1, 16, -1, 1'b0, 1'b0);
    rd(0);
    parity = 2'b11;
    push(0, {2'b00, 9'h0A3});
    send(0, 9'h0A3, 8, 1'b1, 1'b1, 2'b11, 1, 16, -1, 1'b0, 1'b0);
    rd(0);
    parity = 2'b00;

    // 3-tick low glitch well before mid-bit
    drive(0, 1'b0, 3);
    drive(0, 1'b1, 2);
    chk("busy after glitch edge", busy_v[0], 1);
    drive(0, 1'b1, 30);
    chk("busy after glitch", busy_v[0], 0);
    chk("no rdy after glitch", rdy_v[0], 0);
    // only the middle of the three start samples reads low
    drive(0, 1'b0, 1);
    drive(0, 1'b1, 7);
    drive(0, 1'b0, 1);
    drive(0, 1'b1, 30);
    chk("busy after single low sample", busy_v[0], 0);
    chk("no rdy after single low sample", rdy_v[0], 0);

    // framing errors
    push(0, {2'b01, 9'h00F});
    send(0, 9'h00F, 8, 1'b0, 1'b0, 2'b10, 1, 16, -1, 1'b0, 1'b0);
    rd(0);
    push(1, {2'b01, 9'h00F});
    send(1, 9'h00F, 8, 1'b0, 1'b0, 2'b01, 2, 16, -1, 1'b0, 1'b0);
    rd(1);

    // overrun, then commit coincident with read
    push(0, {2'b00, 9'h011});
    send(0, 9'h011, 8, 1'b0, 1'b0, 2'b11, 1, 16, -1, 1'b0, 1'b0);
    send(0, 9'h022, 8, 1'b0, 1'b0, 2'b11, 1, 16, -1, 1'b0, 1'b0);
    chk("data kept on overrun", d0, 8'h11);
    chk("ovr set", ovr_v[0], 1);
    chk("rdy kept on overrun", rdy_v[0], 1);
    push(0, {2'b00, 9'h033});
    send(0, 9'h033, 8, 1'b0, 1'b0, 2'b11, 1, 16, 154, 1'b1, 1'b1);
    chk("data after commit with read", d0, 8'h33);
    chk("ovr after commit with read", ovr_v[0], 0);
    rd(0);

    // reset during data bit 4 of 0xA5
    drive(0, 1'b0, 16);
    drive(0, 1'b1, 16);
    drive(0, 1'b0, 16);
    drive(0, 1'b1, 16);
    drive(0, 1'b0, 16);
    drive(0, 1'b0, 5);
    chk("busy mid-frame", busy_v[0], 1);
    @(posedge i_clk); #1;
    i_nrst = 1'b0;
    rx[0]  = 1'b1;
    @(negedge i_clk);
    chk("busy in reset", busy_v[0], 0);
    chk("data in reset", d0, 8'hFF);
    @(posedge i_clk); #1 i_nrst = 1'b1;
    drive(0, 1'b1, 40);
    chk("no rdy after aborted frame", rdy_v[0], 0);
    push(0, {2'b00, 9'h03C});
    send(0, 9'h03C, 8, 1'b0, 1'b0, 2'b11, 1, 16, -1, 1'b0, 1'b0);
    rd(0);

    // 5-bit, OS=8: 0x16 has three ones
    push(2, {2'b00, 9'h016});
    send(2, 9'h016, 5, 1'b0, 1'b0, 2'b11, 1, 8, -1, 1'b0, 1'b0);
    rd(2);
    parity = 2'b10;
    push(2, {2'b00, 9'h016});
    send(2, 9'h016, 5, 1'b1, 1'b1, 2'b11, 1, 8, -1, 1'b0, 1'b0);
    rd(2);
    parity = 2'b11;
    push(2, {2'b10, 9'h016});
    send(2, 9'h016, 5, 1'b1, 1'b1, 2'b11, 1, 8, -1, 1'b0, 1'b0);
    rd(2);
    parity = 2'b00;

    // 9-bit, OS=8, two stops, ticks back-to-back
    tp = 1;
    push(3, {2'b00, 9'h1A5});
    send(3, 9'h1A5, 9, 1'b0, 1'b0, 2'b11, 2, 8, -1, 1'b0, 1'b0);
    rd(3);
    push(3, {2'b01, 9'h0C3});
    send(3, 9'h0C3, 9, 1'b0, 1'b0, 2'b01, 2, 8, -1, 1'b0, 1'b0);
    rd(3);
    tp = 4;

    repeat (4) @(posedge i_clk);
    chk("queue a drained", q0.size(), 0);
    chk("queue b drained", q1.size(), 0);
    chk("queue c drained", q2.size(), 0);
    chk("queue d drained", q3.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx_os.md
# uart_rx_os

Parametrised oversampling UART receiver, the successor to the existing single-width receiver in the UART core. It samples `i_rx` on an external oversample enable `i_tick` (OS ticks per bit) and takes a 3-sample majority vote at mid-bit. It supports 5–9 data bits, runtime-selectable parity, 1 or 2 stop bits, and per-frame parity and framing error status. An overrun flag covers the single-entry holding register read by the host side through the `o_rdy`/`i_re` handshake.

## Interface
- `WIDTH_DATA`, 8, data bits per frame; legal 5..9.
- `OS`, 16, oversample ticks per bit; even, legal 8..32.
- `STOP_BITS`, 1, stop bits checked; legal 1 or 2.
- `i_clk`  in  1  system clock; everything in this block is on `i_clk`.
- `i_nrst`  in  1  reset; one clock, asynchronous, active-low.
- `i_tick`  in  1  oversample enable, one `i_clk` wide, OS pulses per bit period.
- `i_rx`  in  1  serial line, asynchronous, idle high.
- `i_parity`  in  2  parity mode: 00/01 none, 10 even, 11 odd.
- `i_re`  in  1  host read strobe; consumes the holding register.
- `o_data`  out  WIDTH_DATA  received data, LSB first on the line, right-aligned.
- `o_rdy`  out  1  holding register valid.
- `o_perr`  out  1  parity error of the frame in the holding register.
- `o_ferr`  out  1  framing error (a stop bit read 0) of the frame in the holding register.
- `o_ovr`  out  1  sticky overrun.
- `o_busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- Synchronizer:
  - `i_rx` passes through a 2-FF synchronizer, reset to 1.
  - A falling edge is synchronized value 0 with its previous value 1.
- Tick counter `tc`:
  - Range 0..OS-1. Cleared on entry to START and on every bit boundary.
  - Advances only on `i_tick`.
- Majority vote:
  - Samples are taken on the ticks where tc = OS/2-1, OS/2 and OS/2+1.
  - The bit value is the majority of the three samples, decided on the tick where tc = OS/2+1.
  - The bit period ends on the tick where tc = OS-1.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: a falling edge moves to START. `i_parity` is latched here; changes mid-frame are ignored.
  - START: if the vote is 1, the start was false: return to IDLE with no output and no error. If the vote is 0, go to DATA at the end of the bit period.
  - DATA: WIDTH_DATA bits are shifted in LSB first. Then go to PARITY if parity is enabled, otherwise to STOP.
  - PARITY: the voted bit is checked. Even mode requires the XOR of data and parity bit to be 0; odd mode requires it to be 1.
  - STOP: STOP_BITS bits are voted. Any 0 sets the frame's framing error.
  - On the final stop vote, the frame is committed and the FSM returns to IDLE immediately, not at the end of the bit period. This allows resync to a start edge that follows early.
- Commit (one `i_clk` cycle):
  - `o_rdy` = 0, or `i_re` in the same cycle: load `o_data`, `o_perr` and `o_ferr`, set `o_rdy` = 1.
  - `o_rdy` = 1 and no `i_re`: discard the new frame, keep the old data and flags, set `o_ovr`.
- `i_re` with no commit: `o_rdy`, `o_perr`, `o_ferr` and `o_ovr` clear on the next edge. `o_data` holds its value.
- `i_re` while `o_rdy` = 0: no effect other than clearing `o_ovr`.
- A framing-error frame is still delivered, with `o_ferr` = 1.
- A break (line held low) produces a frame with data 0 and `o_ferr` = 1. The FSM then waits in IDLE for a rising edge followed by a new falling edge; it never re-triggers on a level.

## Timing
- Reset values:
  - `o_data` = all ones.
  - `o_rdy`, `o_perr`, `o_ferr`, `o_ovr`, `o_busy` = 0.
  - FSM = IDLE, `tc` = 0, synchronizer = 11.
- Assertion of `i_nrst` mid-frame aborts the frame with no commit and no flags.
- Edge detection latency: 2 `i_clk` cycles of synchronizer plus 1 cycle of edge detection after `i_rx` falls.
- `o_rdy` rises on the `i_clk` edge after the `i_tick` cycle in which the last stop bit reaches tc = OS/2+1.
- Ticks arriving back-to-back (`i_tick` held high) are legal; each high cycle is one tick.
- Simultaneous commit and `i_re` when `o_rdy` = 1: the new frame is loaded, `o_rdy` stays 1, `o_ovr` stays 0.

## Test plan
- 8N1, OS=16, byte 0x55, then `i_re` → `o_data` = 0x55, `o_rdy` = 1, `o_perr` = `o_ferr` = 0; `o_rdy` = 0 one cycle after `i_re`.
- Even parity, byte 0xA3 sent with parity bit 1 (wrong) → `o_data` = 0xA3, `o_perr` = 1. Repeat in odd mode with parity bit 1 (correct) → `o_perr` = 0.
- Low glitch on `i_rx` lasting 3 ticks, centred off mid-bit; also a single low sample at mid-start → no commit, `o_busy` returns to 0, FSM in IDLE.
- Stop bit driven 0 with data 0x0F; STOP_BITS=2 with only the second stop bit 0 → `o_data` = 0x0F, `o_ferr` = 1 in both cases.
- Two frames (0x11, then 0x22) with no `i_re` → `o_data` = 0x11, `o_ovr` = 1. Then a third frame committed in the same cycle as `i_re` → `o_data` = third byte, `o_rdy` = 1.
- `i_nrst` asserted during data bit 4, then released and a byte 0x3C received → no spurious `o_rdy` before the new frame; `o_data` = 0x3C. Also run WIDTH_DATA=5 and 9 with OS=8.
